// File: rtl/ethernet_transmitter.sv
// Two-slot host-filled packet buffer streamed onto an AXI-Stream master, oldest frame first.
// First beat 2 cycles after commit, then one beat per 2 cycles; tx outputs hold while tready=0.
module ethernet_transmitter #(
  parameter int data_width_p = 32,
  parameter int eth_mtu_p    = 2048,
  parameter int send_count_p = 65535
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  output logic                               packet_req_o,
  input  logic                               packet_wvalid_i,
  input  logic [$clog2(eth_mtu_p)-1:0]       packet_waddr_i,
  input  logic [data_width_p-1:0]            packet_wdata_i,
  input  logic [data_width_p/8-1:0]          packet_wmask_i,
  input  logic                               packet_wsize_valid_i,
  input  logic [$clog2(eth_mtu_p+1)-1:0]     packet_wsize_i,
  input  logic                               packet_send_i,
  output logic [data_width_p-1:0]            tx_axis_tdata_o,
  output logic [data_width_p/8-1:0]          tx_axis_tkeep_o,
  output logic                               tx_axis_tvalid_o,
  input  logic                               tx_axis_tready_i,
  output logic                               tx_axis_tlast_o,
  output logic                               tx_axis_tuser_o,
  output logic [$clog2(send_count_p+1)-1:0]  send_count_o
);

  localparam int B     = data_width_p / 8;
  localparam int BW    = $clog2(B);
  localparam int AW    = $clog2(eth_mtu_p);
  localparam int SW    = $clog2(eth_mtu_p + 1);
  localparam int DEPTH = eth_mtu_p / B;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(send_count_p + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t                  state_q, state_d;
  logic [data_width_p-1:0] mem [2*DEPTH];
  logic                    wr_slot_q, rd_slot_q;
  logic [1:0]              full_q;
  logic [SW-1:0]           size_q [2];
  logic [SW-1:0]           wr_size_q;
  logic [PW-1:0]           ptr_q;
  logic [data_width_p-1:0] rdata_q;
  logic [B-1:0]            keep_q, keep_d;
  logic                    last_q, last_d;
  logic [CW-1:0]           count_q;

  logic          commit, start, advance, done, release_slot;
  logic [SW-1:0] rd_size, byte_off, rem;
  logic [PW:0]   waddr_idx;

  assign packet_req_o = ~full_q[wr_slot_q];
  assign commit       = packet_send_i && packet_req_o;
  assign waddr_idx    = {wr_slot_q, packet_waddr_i[AW-1:BW]};
  assign rd_size      = size_q[rd_slot_q];
  assign byte_off     = SW'(ptr_q) << BW;
  assign rem          = rd_size - byte_off;

  always_comb begin
    keep_d = '0;
    for (int i = 0; i < B; i++) keep_d[i] = (SW'(i) < rem);
    last_d = (rem <= SW'(B));
  end

  always_comb begin
    state_d      = state_q;
    start        = 1'b0;
    advance      = 1'b0;
    done         = 1'b0;
    release_slot = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_slot_q]) begin
          // Zero-length frames are discarded without producing a beat.
          if (rd_size == '0) begin
            release_slot = 1'b1;
          end else begin
            start   = 1'b1;
            state_d = FETCH;
          end
        end
      end
      FETCH: state_d = SEND;
      SEND: begin
        if (tx_axis_tready_i) begin
          if (last_q) begin
            release_slot = 1'b1;
            done         = 1'b1;
            state_d      = IDLE;
          end else begin
            advance = 1'b1;
            state_d = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (packet_wvalid_i && packet_req_o) begin
      for (int b = 0; b < B; b++) begin
        if (packet_wmask_i[b]) mem[waddr_idx][b*8 +: 8] <= packet_wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      rdata_q   <= '0;
      keep_q    <= '0;
      last_q    <= 1'b0;
      count_q   <= '0;
      wr_slot_q <= 1'b0;
      rd_slot_q <= 1'b0;
      full_q    <= '0;
      wr_size_q <= '0;
      size_q[0] <= '0;
      size_q[1] <= '0;
    end else begin
      state_q <= state_d;
      if (start) ptr_q <= '0;
      else if (advance) ptr_q <= ptr_q + 1'b1;
      if (state_q == FETCH) begin
        rdata_q <= mem[{rd_slot_q, ptr_q}];
        keep_q  <= keep_d;
        last_q  <= last_d;
      end
      if (done && count_q != CW'(send_count_p)) count_q <= count_q + 1'b1;
      // A size presented together with the commit overrides any earlier one.
      if (commit) begin
        full_q[wr_slot_q] <= 1'b1;
        size_q[wr_slot_q] <= packet_wsize_valid_i ? packet_wsize_i : wr_size_q;
        wr_slot_q         <= ~wr_slot_q;
        wr_size_q         <= '0;
      end else if (packet_wsize_valid_i && packet_req_o) begin
        wr_size_q <= packet_wsize_i;
      end
      if (release_slot) begin
        full_q[rd_slot_q] <= 1'b0;
        rd_slot_q         <= ~rd_slot_q;
      end
    end
  end

  assign tx_axis_tdata_o  = rdata_q;
  assign tx_axis_tkeep_o  = keep_q;
  assign tx_axis_tlast_o  = last_q;
  assign tx_axis_tvalid_o = (state_q == SEND);
  assign tx_axis_tuser_o  = 1'b0;
  assign send_count_o     = count_q;

  a_size_legal: assert property (@(posedge clk_i) disable iff (!reset_i)
    packet_wsize_valid_i |-> (packet_wsize_i <= SW'(eth_mtu_p)));
  a_host_when_free: assert property (@(posedge clk_i) disable iff (!reset_i)
    (packet_wvalid_i || packet_wsize_valid_i || packet_send_i) |-> packet_req_o);
  a_addr_aligned: assert property (@(posedge clk_i) disable iff (!reset_i)
    packet_wvalid_i |-> (packet_waddr_i[BW-1:0] == '0));

endmodule

// File: tb/tb_ethernet_transmitter.sv
// Scoreboard bench for ethernet_transmitter at 32- and 64-bit data widths.
module tb_ethernet_transmitter;

  typedef struct packed {
    logic [63:0] dat;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic        clk, rst_n, tready;
  logic [1:0]  wvalid, wsize_vld, send;
  logic [10:0] waddr;
  logic [63:0] wdata;
  logic [7:0]  wmask;
  logic [11:0] wsize;

  logic        req32, tvalid32, tlast32, tuser32;
  logic [31:0] tdata32;
  logic [3:0]  tkeep32;
  logic [15:0] cnt32;
  logic        req64, tvalid64, tlast64, tuser64;
  logic [63:0] tdata64;
  logic [7:0]  tkeep64;
  logic [15:0] cnt64;

  beat_t q0[$];
  beat_t q1[$];
  beat_t held_b[2];
  logic  stall_f[2];
  logic  gap_f[2];
  int    hs[2];
  int    tests = 0;
  int    fails = 0;

  ethernet_transmitter #(.data_width_p(32)) u_dut32 (
    .clk_i(clk), .reset_i(rst_n), .packet_req_o(req32),
    .packet_wvalid_i(wvalid[0]), .packet_waddr_i(waddr), .packet_wdata_i(wdata[31:0]),
    .packet_wmask_i(wmask[3:0]), .packet_wsize_valid_i(wsize_vld[0]), .packet_wsize_i(wsize),
    .packet_send_i(send[0]), .tx_axis_tdata_o(tdata32), .tx_axis_tkeep_o(tkeep32),
    .tx_axis_tvalid_o(tvalid32), .tx_axis_tready_i(tready), .tx_axis_tlast_o(tlast32),
    .tx_axis_tuser_o(tuser32), .send_count_o(cnt32));

  ethernet_transmitter #(.data_width_p(64)) u_dut64 (
    .clk_i(clk), .reset_i(rst_n), .packet_req_o(req64),
    .packet_wvalid_i(wvalid[1]), .packet_waddr_i(waddr), .packet_wdata_i(wdata),
    .packet_wmask_i(wmask), .packet_wsize_valid_i(wsize_vld[1]), .packet_wsize_i(wsize),
    .packet_send_i(send[1]), .tx_axis_tdata_o(tdata64), .tx_axis_tkeep_o(tkeep64),
    .tx_axis_tvalid_o(tvalid64), .tx_axis_tready_i(tready), .tx_axis_tlast_o(tlast64),
    .tx_axis_tuser_o(tuser64), .send_count_o(cnt64));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int q_size(input int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [15:0] cnt_of(input int sel);
    return (sel == 0) ? cnt32 : cnt64;
  endfunction

  function automatic logic req_of(input int sel);
    return (sel == 0) ? req32 : req64;
  endfunction

  // Monitor: pops the expected beat on every handshake and checks stall/gap rules.
  task automatic mon_step(input int sel, input logic vld, input logic rdy,
                          input logic [63:0] dat, input logic [7:0] keep, input logic last);
    beat_t cur, e;
    cur = '{dat: dat, keep: keep, last: last};
    if (!rst_n) begin
      stall_f[sel] = 1'b0;
      gap_f[sel]   = 1'b0;
      return;
    end
    if (gap_f[sel]) check($sformatf("gap_vld%0d", sel), {63'h0, vld}, 64'h0);
    gap_f[sel] = 1'b0;
    if (stall_f[sel]) begin
      check($sformatf("stall_vld%0d", sel), {63'h0, vld}, 64'h1);
      check($sformatf("stall_dat%0d", sel), cur.dat, held_b[sel].dat);
      check($sformatf("stall_keep_last%0d", sel), {55'h0, cur.keep, cur.last},
            {55'h0, held_b[sel].keep, held_b[sel].last});
    end
    if (vld && rdy) begin
      hs[sel]++;
      if (q_size(sel) == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat%0d: got data 0x%0h, want no beat", sel, dat);
      end else begin
        e = (sel == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("beat_dat%0d", sel), dat, e.dat);
        check($sformatf("beat_keep%0d", sel), {56'h0, keep}, {56'h0, e.keep});
        check($sformatf("beat_last%0d", sel), {63'h0, last}, {63'h0, e.last});
      end
      gap_f[sel] = !last;
    end
    stall_f[sel] = vld && !rdy;
    held_b[sel]  = cur;
  endtask

  initial begin
    stall_f = '{1'b0, 1'b0};
    gap_f   = '{1'b0, 1'b0};
    hs      = '{0, 0};
    forever begin
      @(negedge clk);
      mon_step(0, tvalid32, tready, {32'h0, tdata32}, {4'h0, tkeep32}, tlast32);
      mon_step(1, tvalid64, tready, tdata64, tkeep64, tlast64);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int sel, input int addr, input logic [63:0] d, input logic [7:0] m);
    waddr = 11'(addr);
    wdata = d;
    wmask = m;
    wvalid[sel] = 1'b1;
    tick();
    wvalid[sel] = 1'b0;
  endtask

  task automatic wait_req(input int sel);
    int n = 0;
    while (!req_of(sel) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      tests++;
      fails++;
      $display("FAIL req_timeout%0d: got req 0, want 1 within 500 cycles", sel);
    end
  endtask

  // mode 0: size latched before the data; 1: size with the commit; 2: no size at all.
  task automatic load_frame(input int sel, input logic [7:0] seed, input int size, input int mode,
                            input logic [7:0] last_keep, input int mask_word);
    int bb, nbeats;
    logic [63:0] d;
    beat_t e;
    bb = (sel == 0) ? 4 : 8;
    nbeats = (size + bb - 1) / bb;
    wait_req(sel);
    if (mode == 0) begin
      wsize = 12'(size);
      wsize_vld[sel] = 1'b1;
      tick();
      wsize_vld[sel] = 1'b0;
    end
    for (int w = 0; w < nbeats; w++) begin
      d = '0;
      for (int b = 0; b < bb; b++) d[b*8 +: 8] = seed + 8'(w*bb + b);
      write_word(sel, w*bb, d, 8'hff);
      if (w == mask_word) begin
        write_word(sel, w*bb, {8{8'ha5}}, 8'b0000_0010);
        d[15:8] = 8'ha5;
      end
      e.dat  = d;
      e.keep = (w == nbeats-1) ? last_keep : ((sel == 0) ? 8'h0f : 8'hff);
      e.last = (w == nbeats-1);
      if (sel == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    wsize = 12'(size);
    if (mode == 1) wsize_vld[sel] = 1'b1;
    send[sel] = 1'b1;
    tick();
    send[sel] = 1'b0;
    wsize_vld[sel] = 1'b0;
  endtask

  task automatic wait_drain(input int sel, input int exp_cnt);
    int n = 0;
    while (!(q_size(sel) == 0 && cnt_of(sel) == 16'(exp_cnt)) && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout%0d: got %0d beats pending, want 0", sel, q_size(sel));
    end
    check($sformatf("send_count%0d", sel), {48'h0, cnt_of(sel)}, 64'(exp_cnt));
  endtask

  initial begin
    int n, vcount;
    rst_n = 1'b0; tready = 1'b1;
    wvalid = '0; wsize_vld = '0; send = '0;
    waddr = '0; wdata = '0; wmask = '0; wsize = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset state.
    check("rst_tvalid32", {63'h0, tvalid32}, 64'h0);
    check("rst_tlast32", {63'h0, tlast32}, 64'h0);
    check("rst_tkeep32", {60'h0, tkeep32}, 64'h0);
    check("rst_tdata32", {32'h0, tdata32}, 64'h0);
    check("rst_cnt32", {48'h0, cnt32}, 64'h0);
    check("rst_req32", {63'h0, req32}, 64'h1);
    check("rst_tuser32", {63'h0, tuser32}, 64'h0);
    check("rst_tvalid64", {63'h0, tvalid64}, 64'h0);
    check("rst_tkeep64", {56'h0, tkeep64}, 64'h0);
    check("rst_tdata64", tdata64, 64'h0);
    check("rst_cnt64", {48'h0, cnt64}, 64'h0);
    check("rst_req64", {63'h0, req64}, 64'h1);

    // 60-byte frame at 32 bits, with one byte-masked overwrite; first-beat latency.
    load_frame(0, 8'h10, 60, 0, 8'h0f, 3);
    tick();
    check("lat_fetch32", {63'h0, tvalid32}, 64'h0);
    tick();
    check("lat_first32", {63'h0, tvalid32}, 64'h1);
    wait_drain(0, 1);

    // 64 bits: size 61 then size 1 (size given with the commit).
    load_frame(1, 8'h40, 61, 0, 8'h1f, -1);
    load_frame(1, 8'h80, 1, 1, 8'h01, -1);
    wait_drain(1, 2);

    // Fill both slots while stalled; req drops, returns after first tlast.
    tready = 1'b0;
    load_frame(0, 8'h20, 20, 1, 8'h0f, -1);
    load_frame(0, 8'h30, 10, 0, 8'h03, -1);
    check("req_full32", {63'h0, req32}, 64'h0);
    repeat (3) tick();
    check("req_held32", {63'h0, req32}, 64'h0);
    tready = 1'b1;
    n = 0;
    while (!req32 && n < 200) begin
      tick();
      n++;
    end
    check("req_back32", {63'h0, req32}, 64'h1);
    check("pending_after_first", 64'(q0.size()), 64'd3);
    check("cnt_after_first", {48'h0, cnt32}, 64'd2);
    wait_drain(0, 3);

    // Random tready with a 10-cycle stall mid-frame.
    load_frame(0, 8'h50, 32, 0, 8'h0f, -1);
    for (int c = 0; c < 400; c++) begin
      if (q0.size() == 0 && cnt32 == 16'd4) break;
      tready = (c >= 4 && c < 14) ? 1'b0 : 1'($urandom_range(0, 1));
      tick();
    end
    tready = 1'b1;
    wait_drain(0, 4);

    // Size-0 commit (no size given) is dropped and its slot freed quickly.
    load_frame(1, 8'h00, 0, 2, 8'h00, -1);
    load_frame(1, 8'h60, 8, 1, 8'hff, -1);
    check("req_after_zero64", {63'h0, req64}, 64'h1);
    wait_drain(1, 3);

    // Reset at beat 3 of a 16-beat frame.
    n = hs[0];
    load_frame(0, 8'h70, 64, 0, 8'h0f, -1);
    vcount = 0;
    while (!(hs[0] - n >= 2 && tvalid32) && vcount < 200) begin
      tick();
      vcount++;
    end
    check("beat3_visible", {63'h0, tvalid32}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_tvalid32", {63'h0, tvalid32}, 64'h0);
    check("arst_tlast32", {63'h0, tlast32}, 64'h0);
    check("arst_cnt32", {48'h0, cnt32}, 64'h0);
    check("arst_cnt64", {48'h0, cnt64}, 64'h0);
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("post_rst_req32", {63'h0, req32}, 64'h1);
    vcount = 0;
    repeat (30) begin
      tick();
      if (tvalid32) vcount++;
    end
    check("residual_beats", 64'(vcount), 64'h0);
    check("post_rst_cnt32", {48'h0, cnt32}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
